// File: rtl/pwm_pkg.sv
// Shared constants, duty type and threshold helper for the ramped PWM array.
package pwm_pkg;

  localparam int unsigned DEF_DUTY_W    = 10;
  localparam int unsigned DEF_PERIOD    = 4000;
  localparam int unsigned DEF_CNT_W     = 12;
  localparam int unsigned DEF_RAMP_STEP = 16;

  typedef logic [DEF_DUTY_W-1:0] duty_t;

  // High-time threshold in counter ticks: (period * duty) >> duty_w, truncated.
  function automatic logic [31:0] duty_to_thr(input logic [31:0] period,
                                              input logic [31:0] duty,
                                              input int unsigned duty_w);
    logic [63:0] prod;
    prod = 64'(period) * 64'(duty);
    prod = prod >> duty_w;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/pwm_ramp_ch.sv
// One PWM channel: slew-limited active duty, threshold register, brake and output flop.
module pwm_ramp_ch
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              boundary,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [DUTY_W-1:0] target,
  input  logic              brake,
  output logic              pwm,
  output logic              at_target,
  output logic [DUTY_W-1:0] duty_act
);

  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

  logic [DUTY_W-1:0] duty_q, duty_d, ramped, diff;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic              pwm_q, pwm_d;

  // Move toward target by at most STEP; a smaller remaining gap lands exactly on target.
  always_comb begin
    ramped = duty_q;
    diff   = '0;
    if (RAMP_STEP == 0) begin
      ramped = target;
    end else if (target > duty_q) begin
      diff   = target - duty_q;
      ramped = (32'(diff) > RAMP_STEP) ? duty_q + STEP : target;
    end else if (target < duty_q) begin
      diff   = duty_q - target;
      ramped = (32'(diff) > RAMP_STEP) ? duty_q - STEP : target;
    end
  end

  always_comb begin
    duty_d = duty_q;
    thr_d  = thr_q;
    if (!enable || brake) begin
      duty_d = '0;
      thr_d  = '0;
    end else if (boundary) begin
      duty_d = ramped;
      thr_d  = CNT_W'(duty_to_thr(PERIOD, 32'(ramped), DUTY_W));
    end
    pwm_d = enable & ~brake & (cnt < thr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      thr_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      thr_q  <= thr_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm       = pwm_q;
  assign duty_act  = duty_q;
  assign at_target = (duty_q == target);

endmodule

// File: rtl/pwm_ramp_array.sv
// Multi-channel phase-aligned PWM: shared period counter, per-channel slew-limited duty.
module pwm_ramp_array
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_CH*DUTY_W-1:0]   duty_target,
  input  logic [N_CH-1:0]          brake,
  output logic [N_CH-1:0]          pwm,
  output logic                     period_start,
  output logic [N_CH-1:0]          at_target,
  output logic [N_CH*DUTY_W-1:0]   duty_active
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boundary;
  logic             ps_q;

  always_comb begin
    boundary = enable && (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d    = (!enable || boundary) ? '0 : cnt_q + 1'b1;
  end

  // period_start is the registered boundary, so it lines up with the first cnt==0 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= boundary;
    end
  end

  assign period_start = ps_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_ramp_ch #(
      .DUTY_W    (DUTY_W),
      .PERIOD    (PERIOD),
      .CNT_W     (CNT_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .boundary  (boundary),
      .cnt       (cnt_q),
      .target    (duty_target[i*DUTY_W +: DUTY_W]),
      .brake     (brake[i]),
      .pwm       (pwm[i]),
      .at_target (at_target[i]),
      .duty_act  (duty_active[i*DUTY_W +: DUTY_W])
    );
  end

endmodule

// File: tb/tb_pwm_ramp_array.sv
// Randomised and directed bench for pwm_ramp_array against an integer reference model.
module tb_pwm_ramp_array;

  localparam int unsigned NC = 2;
  localparam int unsigned DW = 10;
  localparam int unsigned P  = 40;
  localparam int unsigned CW = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NC*DW-1:0]  duty_target;
  logic [NC-1:0]     brake;

  logic [NC-1:0]     pwm_o [2];
  logic              ps_o  [2];
  logic [NC-1:0]     at_o  [2];
  logic [NC*DW-1:0]  da_o  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = unlimited ramp, index 1 = step 16.
  int steps [2] = '{0, 16};
  int m_cnt;
  bit m_ps;
  int m_dact [2][NC];
  int m_thr  [2][NC];
  bit m_pwm  [2][NC];
  int hi [2][NC];
  int ps_n;

  always #5 clk = ~clk;

  pwm_ramp_array #(
    .N_CH(NC), .DUTY_W(DW), .PERIOD(P), .CNT_W(CW), .RAMP_STEP(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .duty_target(duty_target), .brake(brake),
    .pwm(pwm_o[0]), .period_start(ps_o[0]), .at_target(at_o[0]), .duty_active(da_o[0])
  );

  pwm_ramp_array #(
    .N_CH(NC), .DUTY_W(DW), .PERIOD(P), .CNT_W(CW), .RAMP_STEP(16)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .duty_target(duty_target), .brake(brake),
    .pwm(pwm_o[1]), .period_start(ps_o[1]), .at_target(at_o[1]), .duty_active(da_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt(input int i);
    logic [DW-1:0] v;
    v = duty_target[i*DW +: DW];
    return int'(v);
  endfunction

  function automatic int ramp(input int d, input int t, input int s);
    if (s == 0) return t;
    if (t > d) return d + ((t - d) < s ? (t - d) : s);
    if (t < d) return d - ((d - t) < s ? (d - t) : s);
    return d;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_ps  = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NC; i++) begin
        m_dact[k][i] = 0;
        m_thr[k][i]  = 0;
        m_pwm[k][i]  = 0;
      end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit b;
    b = enable && (m_cnt == P - 1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NC; i++) begin
        m_pwm[k][i] = enable && !brake[i] && (m_cnt < m_thr[k][i]);
        if (!enable || brake[i]) begin
          m_dact[k][i] = 0;
          m_thr[k][i]  = 0;
        end else if (b) begin
          m_dact[k][i] = ramp(m_dact[k][i], tgt(i), steps[k]);
          m_thr[k][i]  = (P * m_dact[k][i]) / 1024;
        end
      end
    m_ps  = b;
    m_cnt = (!enable || b) ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("period_start dut%0d", k), 32'(ps_o[k]), 32'(m_ps));
      for (int i = 0; i < NC; i++) begin
        check($sformatf("pwm dut%0d ch%0d", k, i), 32'(pwm_o[k][i]), 32'(m_pwm[k][i]));
        check($sformatf("duty dut%0d ch%0d", k, i), 32'(da_o[k][i*DW +: DW]),
              32'(m_dact[k][i]));
        check($sformatf("at_target dut%0d ch%0d", k, i), 32'(at_o[k][i]),
              32'(m_dact[k][i] == tgt(i)));
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ps_o[0] && n < 3 * P);
    if (!ps_o[0]) check("period_start timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 2 * P) begin
      tick();
      n++;
    end
  endtask

  // Count high cycles of both DUTs over exactly one period, starting right after a period_start.
  task automatic count_period();
    int n;
    wait_ps(n);
    ps_n = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NC; i++) hi[k][i] = 0;
    for (int j = 0; j < P; j++) begin
      tick();
      ps_n += int'(ps_o[0]);
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NC; i++) hi[k][i] += int'(pwm_o[k][i]);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    enable = 1'b0;
    brake = '0;
    duty_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Steady duty, unlimited ramp.
    duty_target = {10'd256, 10'd512};
    enable = 1'b1;
    run(3 * P);
    count_period();
    check("steady hi ch0", 32'(hi[0][0]), P * 512 / 1024);
    check("steady hi ch1", 32'(hi[0][1]), P * 256 / 1024);
    check("period_start per period", 32'(ps_n), 32'd1);

    // Full-range ramp up from 0.
    brake = 2'b11;
    tick();
    brake = 2'b00;
    duty_target = {10'd1023, 10'd1023};
    run(66 * P);
    check("ramp up at_target", 32'(at_o[1]), 32'd3);
    check("ramp up duty", 32'(da_o[1][DW-1:0]), 32'd1023);
    count_period();
    check("full scale hi", 32'(hi[1][0]), P * 1023 / 1024);

    // Ramp down after a mid-period target change.
    wait_cnt(15);
    duty_target = '0;
    run(66 * P);
    check("ramp down duty", 32'(da_o[1][DW-1:0]), 32'd0);

    // Brake pulse on channel 1 during 50% duty.
    duty_target = {10'd512, 10'd512};
    run(34 * P);
    wait_cnt(10);
    brake = 2'b10;
    tick();
    check("brake pwm1 low", 32'(pwm_o[1][1]), 32'd0);
    check("brake ch0 high", 32'(pwm_o[1][0]), 32'd1);
    brake = 2'b00;
    wait_ps(n);
    check("brake restart 16", 32'(da_o[1][DW +: DW]), 32'd16);
    run(3 * P);

    // Asynchronous reset mid-period.
    wait_cnt(21);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("reset pwm", 32'(pwm_o[1]), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    enable = 1'b0;
    reset = 1'b0;

    // Enable held low, then first boundary a full period after re-enable.
    run(10);
    enable = 1'b1;
    wait_ps(n);
    check("first B after enable", 32'(n), P);

    // Smallest thresholds.
    duty_target = {10'd0, 10'd26};
    run(2 * P);
    count_period();
    check("thr1 hi", 32'(hi[0][0]), 32'd1);
    check("zero duty hi", 32'(hi[0][1]), 32'd0);

    // Randomised targets, brake pulses and enable drops.
    for (int j = 0; j < 4000; j++) begin
      if ($urandom_range(19) == 0) duty_target[0 +: DW] = DW'($urandom);
      if ($urandom_range(19) == 0) duty_target[DW +: DW] = DW'($urandom);
      brake  = ($urandom_range(63) == 0) ? NC'($urandom) : '0;
      enable = ($urandom_range(299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
